// File: rtl/ifu_sram_responder.sv
// ----------------------------------------------------------------------------
// ifu_sram_responder
//
// Memory-side responder for the instruction-fetch request/response handshake.
// Accepts one fetch at a time, waits LATENCY (+ optional 0..3 jitter) cycles,
// then returns the addressed 32-bit word from an internal word-addressed array,
// or an error for a misaligned or out-of-range address.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. On the request side the transfer is the acceptance, and req_addr
// is sampled only then. On the response side rsp_valid/rsp_data/rsp_err stay
// stable from the edge that raises rsp_valid until the edge where rsp_ready
// is also high.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   req_valid  in   fetch request valid
//   req_ready  out  responder idle and able to accept a request
//   req_addr   in   fetch byte address (WIDTH bits)
//   rsp_valid  out  response valid
//   rsp_ready  in   requester accepts the response
//   rsp_data   out  instruction word (0 on error)
//   rsp_err    out  address misaligned or out of range
//   load_we    in   preload write enable (any state)
//   load_addr  in   preload word index
//   load_data  in   preload data
//   busy       out  a request is in flight
//   dbg_state  out  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ----------------------------------------------------------------------------
module ifu_sram_responder #(
   parameter int                 WIDTH     = 32,
   parameter int                 DEPTH     = 1024,
   parameter logic [WIDTH-1:0]   BASE_ADDR = 32'h8000_0000,
   parameter int                 LATENCY   = 2,
   parameter int                 JITTER    = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [WIDTH-1:0]           req_addr,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_data,
   output logic                       rsp_err,
   input  logic                       load_we,
   input  logic [$clog2(DEPTH)-1:0]   load_addr,
   input  logic [31:0]                load_data,
   output logic                       busy,
   output logic [1:0]                 dbg_state
);

   localparam int AW = $clog2(DEPTH);
   // Counter must hold LATENCY-1+3 at most.
   localparam int CW = $clog2(LATENCY + 4);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [AW-1:0]     idx_q;
   logic              err_q;
   logic [7:0]        lfsr_q;
   logic [7:0]        lfsr_d;

   logic [31:0]       mem [DEPTH];

   logic [WIDTH-3:0]  off_w;
   logic              req_err;
   logic [1:0]        jit;

   // Word offset from the base; addresses below BASE_ADDR wrap to huge
   // offsets and so land in the out-of-range check.
   assign off_w   = (WIDTH-2)'((req_addr - BASE_ADDR) >> 2);
   // DEPTH is a power of two, so "offset >= DEPTH" is "any bit above AW set".
   assign req_err = (req_addr[1:0] != 2'b00) || ((off_w >> AW) != '0);
   assign jit     = (JITTER != 0) ? lfsr_q[1:0] : 2'b00;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; nonzero seed keeps it off all-zero.
   assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

   // Preload port. Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem[load_addr] <= load_data;
      end
   end

   // Main FSM. The read of mem on the WAIT->RESP edge sees the pre-write
   // value if a preload hits the same index on that edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         lfsr_q    <= 8'hA5;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  idx_q   <= off_w[AW-1:0];
                  err_q   <= req_err;
                  cnt_q   <= CW'(LATENCY - 1) + CW'(jit);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  state_q   <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err_q;
                  rsp_data  <= err_q ? 32'h0 : mem[idx_q];
               end
            end
            S_RESP: begin
               // rsp_data/rsp_err intentionally keep their last values.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ifu_sram_responder.md
Name: ifu_sram_responder

Overview:
- Memory-side responder for the instruction-fetch request/response handshake.
- Accepts one fetch request at a time and waits a parameterised, optionally jittered, number of cycles.
- Returns the addressed 32-bit instruction word, or an error, from an internal word-addressed array.
- Sits between the IFU and instruction storage. It replaces the zero-latency fetch path so the core's valid/ready handling is exercised under real latency and backpressure.

Parameters:
- WIDTH, 32, address width in bits.
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, minimum cycles from request acceptance to rsp_valid; legal range is 1 or more.
- JITTER, 0, when 1 adds 0-3 extra cycles per request, taken from an internal LFSR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  WIDTH  fetch byte address; sampled only at acceptance.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  requester accepts the response.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  address misaligned or out of range.
- load_we  in  1  preload write enable.
- load_addr  in  $clog2(DEPTH)  preload word index.
- load_data  in  32  preload data.
- busy  out  1  a request is in flight (state is not IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Delay counter=0, LFSR=8'hA5.
  - req_ready=1 and busy=0 as soon as reset releases.
  - Array contents are not reset.
  - Reset during WAIT or RESP drops the pending request; rsp_valid falls with no clock edge.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE), decoded from state; only one request is outstanding.
- IDLE:
  - On an edge with req_valid && req_ready: latch req_addr, compute err, load counter = LATENCY-1+jit, go to WAIT.
  - jit = JITTER ? lfsr[1:0] : 0.
- err computation:
  - off = req_addr - BASE_ADDR, unsigned WIDTH-bit, wrapping.
  - err = (req_addr[1:0] != 0) || (off[WIDTH-1:2] >= DEPTH).
  - Addresses below BASE_ADDR wrap to large offsets and therefore raise err.
- WAIT:
  - While counter != 0, decrement it each edge.
  - At the edge where counter==0, go to RESP and register outputs:
    - rsp_data = err ? 0 : mem[off[2+:$clog2(DEPTH)]]
    - rsp_err = err
    - rsp_valid = 1
  - Net latency: acceptance at edge t gives rsp_valid high after edge t+LATENCY+jit.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On an edge with rsp_valid && rsp_ready: rsp_valid=0, go to IDLE. rsp_data and rsp_err keep their last values.
  - The next request is accepted no earlier than the following edge.
  - req_valid is ignored in WAIT and RESP.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle regardless of state, never all-zero.
- Preload port:
  - On an edge with load_we, mem[load_addr] <= load_data, in any state.
  - If a load hits the same index on the WAIT->RESP read edge, the response returns the old word (read-before-write).
- Changes on req_addr after acceptance have no effect.

Test Plan:
- Basic fetch:
  - Setup: preload mem[0]=0x00000413, mem[1]=0x00100093; LATENCY=2, JITTER=0; rsp_ready=1.
  - Stimulus: request 0x80000000 accepted at edge t.
  - Required: rsp_valid high after edge t+2 for one cycle, rsp_data=0x00000413, rsp_err=0. A following request to 0x80000004 returns 0x00100093.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles with rsp_valid=1, and drive req_valid=1 with a new address.
  - Required: rsp_data and rsp_err stable, req_ready=0, busy=1, the new request is not accepted. After rsp_ready=1 for one edge: IDLE, req_ready=1.
- Error cases (DEPTH=1024):
  - 0x80000002 -> rsp_err=1, rsp_data=0.
  - 0x80001000 -> rsp_err=1, rsp_data=0.
  - 0x7FFFFFFC -> rsp_err=1, rsp_data=0.
  - 0x80000FFC -> rsp_err=0, returns mem[1023].
- Jitter (JITTER=1, LATENCY=2):
  - Stimulus: 200 random in-range fetches.
  - Required: every latency within 2..5, all four values occur, all data matches the preload model.
- Async reset mid-operation:
  - Stimulus: drop rst in WAIT, and separately in RESP.
  - Required: rsp_valid=0 and busy=0 immediately with no clock edge. After release, req_ready=1 and a new fetch completes with correct data.
- Load collision:
  - Stimulus: load_we to index 1 with 0xDEADBEEF on the WAIT->RESP edge of a fetch to 0x80000004.
  - Required: the response returns the old 0x00100093; the next fetch returns 0xDEADBEEF.
